// File: rtl/micro_udp_engine_arp_rx_mw.sv
// ARP receive parser: assembles the 28-byte ARP body from a 64/128/256-bit stream, validates it, drives table inserts and a reply queue.
// Eop -> insert/push in 2 cycles; sink never stalls, full reply queue drops. Counters only with MICRO_UDP_ENGINE_ARP_RX_STATS_EN.
`timescale 1ns/1ps
module micro_udp_engine_arp_rx_mw #(
    parameter int unsigned DATA_W           = 256,
    parameter logic [47:0] CONFIG_MAC_ADDR  = 48'h0,
    parameter logic [31:0] CONFIG_IP_ADDR   = 32'h0,
    parameter int unsigned REPLY_FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DATA_W-1:0]             arp_rx_data,
    input  logic [$clog2(DATA_W/8)-1:0]   arp_rx_empty,
    input  logic                          arp_rx_startofpacket,
    input  logic                          arp_rx_endofpacket,
    input  logic                          arp_rx_valid,
    output logic                          arp_table_insert,
    output logic [47:0]                   arp_table_mac,
    output logic [31:0]                   arp_table_ipv4,
    output logic                          arp_reply_valid,
    input  logic                          arp_reply_ready,
    output logic [47:0]                   arp_reply_tha,
    output logic [31:0]                   arp_reply_tpa,
    output logic [15:0]                   stat_rx_ok,
    output logic [15:0]                   stat_rx_err,
    output logic [15:0]                   stat_reply_drop
);

    localparam int unsigned BYTES   = DATA_W / 8;
    localparam int unsigned ARP_LEN = 28;
    localparam int unsigned N_BEATS = (ARP_LEN * 8 + DATA_W - 1) / DATA_W;
    localparam int unsigned CAP_W   = N_BEATS * DATA_W;
    localparam int unsigned BEAT_W  = 3;
    localparam int unsigned AW      = $clog2(REPLY_FIFO_DEPTH);
    localparam int unsigned CNT_W   = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_EVAL,
        S_ERR
    } state_t;

    typedef struct packed {
        logic [47:0] tha;
        logic [31:0] tpa;
    } reply_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [BEAT_W-1:0]   beats_before;
    logic [CAP_W-1:0]    cap_q, cap_d;
    logic                cap_en;
    logic [15:0]         bytes_rx;
    logic                enough;

    // Beat index of the current beat within its packet; a sop beat always restarts at zero.
    assign beats_before = arp_rx_startofpacket ? '0 : beat_q;
    assign bytes_rx     = 16'(beats_before) * 16'(BYTES) + 16'(BYTES) - 16'(arp_rx_empty);
    assign enough       = (bytes_rx >= 16'(ARP_LEN));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cap_en  = 1'b0;
        if (state_q != S_COLLECT) begin
            state_d = S_IDLE;
        end
        if (arp_rx_valid && (arp_rx_startofpacket || state_q == S_COLLECT)) begin
            cap_en = (beats_before < BEAT_W'(N_BEATS));
            beat_d = cap_en ? beats_before + BEAT_W'(1) : beats_before;
            if (arp_rx_endofpacket) begin
                state_d = enough ? S_EVAL : S_ERR;
            end else begin
                state_d = S_COLLECT;
            end
        end
    end

    always_comb begin
        cap_d = cap_q;
        for (int k = 0; k < int'(N_BEATS); k++) begin
            if (cap_en && beats_before == BEAT_W'(k)) begin
                cap_d[CAP_W-1-k*DATA_W -: DATA_W] = arp_rx_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            beat_q <= '0;
            cap_q  <= '0;
        end else begin
            beat_q <= beat_d;
            cap_q  <= cap_d;
        end
    end

    logic [15:0] f_htype, f_ptype, f_oper;
    logic [7:0]  f_hlen, f_plen;
    logic [47:0] f_sha;
    logic [31:0] f_spa, f_tpa;

    assign f_htype = cap_q[CAP_W-1   -: 16];
    assign f_ptype = cap_q[CAP_W-17  -: 16];
    assign f_hlen  = cap_q[CAP_W-33  -: 8];
    assign f_plen  = cap_q[CAP_W-41  -: 8];
    assign f_oper  = cap_q[CAP_W-49  -: 16];
    assign f_sha   = cap_q[CAP_W-65  -: 48];
    assign f_spa   = cap_q[CAP_W-113 -: 32];
    assign f_tpa   = cap_q[CAP_W-193 -: 32];

    logic hdr_ok, eval_pass, ins_req, push_req, ok_inc, err_inc;

    always_comb begin
        hdr_ok    = (f_htype == 16'h0001) && (f_ptype == 16'h0800) &&
                    (f_hlen == 8'd6) && (f_plen == 8'd4) &&
                    ((f_oper == 16'd1) || (f_oper == 16'd2));
        eval_pass = (state_q == S_EVAL) && hdr_ok;
        ins_req   = eval_pass && (f_spa != 32'h0);
        push_req  = eval_pass && (f_oper == 16'd1) && (f_tpa == CONFIG_IP_ADDR);
        ok_inc    = eval_pass;
        // A sop while collecting aborts the packet in flight; at most one error source is active per cycle.
        err_inc   = ((state_q == S_EVAL) && !hdr_ok) || (state_q == S_ERR) ||
                    (arp_rx_valid && arp_rx_startofpacket && state_q == S_COLLECT);
    end

    logic        insert_q;
    logic [47:0] mac_q;
    logic [31:0] ipv4_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            insert_q <= 1'b0;
            mac_q    <= '0;
            ipv4_q   <= '0;
        end else begin
            insert_q <= ins_req;
            if (ins_req) begin
                mac_q  <= f_sha;
                ipv4_q <= f_spa;
            end
        end
    end

    assign arp_table_insert = insert_q;
    assign arp_table_mac    = mac_q;
    assign arp_table_ipv4   = ipv4_q;

    reply_t            fifo_q [REPLY_FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              fifo_full, fifo_pop, fifo_push, fifo_drop;

    assign fifo_full = (count_q == CNT_W'(REPLY_FIFO_DEPTH));
    assign fifo_pop  = (count_q != '0) && arp_reply_ready;
    assign fifo_push = push_req && (!fifo_full || fifo_pop);
    assign fifo_drop = push_req && fifo_full && !fifo_pop;

    always_comb begin
        count_d = count_q;
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(REPLY_FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (fifo_push) begin
                fifo_q[wr_ptr_q] <= '{tha: f_sha, tpa: f_spa};
                wr_ptr_q         <= wr_ptr_q + AW'(1);
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    assign arp_reply_valid = (count_q != '0);
    assign arp_reply_tha   = fifo_q[rd_ptr_q].tha;
    assign arp_reply_tpa   = fifo_q[rd_ptr_q].tpa;

`ifdef MICRO_UDP_ENGINE_ARP_RX_STATS_EN
    logic [15:0] ok_cnt_q, err_cnt_q, drop_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ok_cnt_q   <= '0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (ok_inc && ok_cnt_q != 16'hFFFF) begin
                ok_cnt_q <= ok_cnt_q + 16'd1;
            end
            if (err_inc && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
            if (fifo_drop && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign stat_rx_ok      = ok_cnt_q;
    assign stat_rx_err     = err_cnt_q;
    assign stat_reply_drop = drop_cnt_q;

    logic unused_ok;
    assign unused_ok = ^{CONFIG_MAC_ADDR, cap_q};
`else
    assign stat_rx_ok      = 16'h0;
    assign stat_rx_err     = 16'h0;
    assign stat_reply_drop = 16'h0;

    logic unused_ok;
    assign unused_ok = ^{CONFIG_MAC_ADDR, cap_q, ok_inc, err_inc, fifo_drop};
`endif

endmodule

// File: doc/micro_udp_engine_arp_rx_mw.md
# micro_udp_engine_arp_rx_mw

Multi-width ARP receive parser for the micro UDP engine, sitting between the Ethernet RX demux (EtherType 0x0806 stream, Ethernet header stripped) and the ARP table / ARP TX blocks. It assembles the 28-byte ARP body over one or more beats of a parametrised-width Avalon-ST stream and validates every header field. It then issues ARP-table inserts and queues reply requests in a small FIFO with a valid/ready handshake toward ARP TX.

## Interface
- DATA_W, 256: stream width in bits; legal values 64, 128, 256.
- CONFIG_MAC_ADDR, 48'h0: own MAC address (informational; not used for filtering).
- CONFIG_IP_ADDR, 32'h0: own IPv4 address; requests targeting it generate replies.
- REPLY_FIFO_DEPTH, 4: reply queue depth; power of two, 2..16.
- clk  in  1  single clock.
- reset_n  in  1  reset, synchronous, active-low.
- arp_rx_data  in  DATA_W  payload; first byte in bits [DATA_W-1 -: 8].
- arp_rx_empty  in  $clog2(DATA_W/8)  unused bytes on eop beat.
- arp_rx_startofpacket / arp_rx_endofpacket / arp_rx_valid  in  1 each  Avalon-ST framing. Sink has no ready; every valid beat is consumed.
- arp_table_insert  out  1  one-cycle strobe.
- arp_table_mac  out  48  SHA of accepted packet.
- arp_table_ipv4  out  32  SPA of accepted packet.
- arp_reply_valid  out  1  reply-FIFO head valid.
- arp_reply_ready  in  1  ARP TX pops head when valid && ready.
- arp_reply_tha  out  48  head entry: requester MAC.
- arp_reply_tpa  out  32  head entry: requester IP.
- stat_rx_ok / stat_rx_err / stat_reply_drop  out  16 each  saturating counters.

## Operation
- Beats needed: N = ceil(224/DATA_W) (4, 2, 1). A shift register captures the first 28 bytes. Bytes past 28 (padding) are ignored.
- FSM states:
  - IDLE: valid&&sop → COLLECT. If eop is also set, go to EVAL directly when bytes ≥ 28, else ERR.
  - COLLECT: count beats. valid&&sop → abort current (ERR accounting) and restart with this beat. valid&&eop with <28 bytes received → ERR. Eop after ≥28 bytes → EVAL.
  - EVAL (one cycle):
    - Check htype=1, ptype=0x0800, hlen=6, plen=4, oper∈{1,2}.
    - Pass → insert (if SPA≠0); reply push if oper=1 and TPA==CONFIG_IP_ADDR; stat_rx_ok++.
    - Fail → stat_rx_err++.
    - → IDLE.
  - ERR (one cycle): stat_rx_err++ → IDLE.
- Beats with valid but no sop in IDLE are discarded silently.
- Bytes received on eop beat = DATA_W/8 − empty.
- A sop beat arriving while in EVAL/ERR is captured (start of new packet); EVAL/ERR bookkeeping is not lost.
- Reply FIFO:
  - Push when not full, or when full and popping in the same cycle.
  - Push with full and no pop → entry dropped, stat_reply_drop++.
  - Pop when valid && ready.
  - Order preserved.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values: arp_table_insert 0, arp_table_mac 0, arp_table_ipv4 0, arp_reply_valid 0, arp_reply_tha 0, arp_reply_tpa 0, all stats 0. FSM to IDLE, FIFO emptied.
- Reset mid-packet discards the partial packet and any queued replies.
- Latency: eop beat at cycle T → EVAL at T+1 → insert strobe, table data, and FIFO write at T+2.
- arp_reply_valid rises at T+2 when the FIFO was empty (no fall-through bypass).
- Table data is held until the next insert.
- FIFO outputs are stable while valid && !ready.

## Configuration
- MICRO_UDP_ENGINE_ARP_RX_STATS_EN defined: the three saturating counters are implemented.
- Not defined: stat_* outputs are tied to 16'h0 and no counter logic is synthesised; all other behaviour is identical.

## Test plan
- DATA_W=64, valid request (SHA 02:00:00:00:00:01, SPA 0xC0A80105, TPA 0xC0A8010A = CONFIG_IP_ADDR) over 4 beats plus padding → insert with those values at eop+2; reply valid with tha=02:00:00:00:00:01, tpa=0xC0A80105; stat_rx_ok=1.
- DATA_W=256, single-beat reply (oper=2) → insert only, no reply push.
- DATA_W=128, packet with hlen=8 → no insert, stat_rx_err=1; a truncated packet (eop after 16 bytes) → stat_rx_err=2.
- Gratuitous/probe request with SPA=0 and TPA=own IP → reply queued, no insert.
- REPLY_FIFO_DEPTH=4, arp_reply_ready=0, 6 matching requests → 4 queued in order, stat_reply_drop=2; then ready=1 → 4 pops in arrival order.
- Sop mid-packet (second sop at beat 2 of 4, DATA_W=64) → first packet counted as error, second parsed normally; reset_n=0 mid-packet → all outputs 0 on the next cycle.
